// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU issue stage.
//   alu_op_t : opcode driven to picorv32_alu
//   dec_t    : decoded instruction fields produced by alu_decoder
package alu_pkg;

    localparam int unsigned XLEN_W = 32;
    localparam int unsigned REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD     = 4'h0,
        ALU_SUB     = 4'h1,
        ALU_AND     = 4'h2,
        ALU_OR      = 4'h3,
        ALU_XOR     = 4'h4,
        ALU_INVALID = 4'hF
    } alu_op_t;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_XOR     = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        alu_op_t              op;
        logic [REG_AW-1:0]    rs1;
        logic [REG_AW-1:0]    rs2;
        logic [REG_AW-1:0]    rd;
        logic [XLEN_W-1:0]    imm;
        logic                 use_imm;
        logic                 legal;
    } dec_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational RV32I ALU-subset decoder.
//   instr : 32-bit instruction word
//   dec_c : decoded op, register indices, sign-extended imm, use_imm, legal
module alu_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Field extraction is unconditional; only op/use_imm/legal depend on the encoding.
    always_comb begin
        dec_c         = '0;
        dec_c.op      = ALU_INVALID;
        dec_c.rd      = instr[11:7];
        dec_c.rs1     = instr[19:15];
        dec_c.rs2     = instr[24:20];
        dec_c.imm     = {{20{instr[31]}}, instr[31:20]};
        dec_c.use_imm = 1'b0;
        dec_c.legal   = 1'b0;

        case (opcode)
            OPC_OP: begin
                case (funct3)
                    F3_ADD_SUB: begin
                        if (funct7 == F7_BASE) begin
                            dec_c.op    = ALU_ADD;
                            dec_c.legal = 1'b1;
                        end else if (funct7 == F7_SUB) begin
                            dec_c.op    = ALU_SUB;
                            dec_c.legal = 1'b1;
                        end
                    end
                    F3_AND: if (funct7 == F7_BASE) begin
                        dec_c.op    = ALU_AND;
                        dec_c.legal = 1'b1;
                    end
                    F3_OR: if (funct7 == F7_BASE) begin
                        dec_c.op    = ALU_OR;
                        dec_c.legal = 1'b1;
                    end
                    F3_XOR: if (funct7 == F7_BASE) begin
                        dec_c.op    = ALU_XOR;
                        dec_c.legal = 1'b1;
                    end
                    default: ;
                endcase
            end
            OPC_OPIMM: begin
                dec_c.use_imm = 1'b1;
                case (funct3)
                    F3_ADD_SUB: begin dec_c.op = ALU_ADD; dec_c.legal = 1'b1; end
                    F3_AND:     begin dec_c.op = ALU_AND; dec_c.legal = 1'b1; end
                    F3_OR:      begin dec_c.op = ALU_OR;  dec_c.legal = 1'b1; end
                    F3_XOR:     begin dec_c.op = ALU_XOR; dec_c.legal = 1'b1; end
                    default:    ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage in front of picorv32_alu.
// D: decode + operand read (with forwarding from E) -> E register drives alu_*;
// E: alu_result written back to the register file and registered on wb_*.
//   clk, rst               : clock, async active-high reset
//   instr_valid/ready      : instruction handshake (ready = !hold)
//   instr, hold            : instruction word, whole-stage freeze
//   alu_a/alu_b/alu_op     : ALU operands and opcode (from E register)
//   alu_result             : combinational ALU result
//   wb_valid/wb_rd/wb_data : registered writeback
//   illegal                : one-cycle pulse for unsupported instruction
//   retired_count          : legal instructions retired (wraps)
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    input  logic            hold,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_result,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            illegal,
    output logic [31:0]     retired_count
);

    localparam int unsigned AW = REG_AW;

    dec_t dec_c;

    alu_decoder u_dec (
        .instr (instr),
        .dec_c (dec_c)
    );

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];

    logic            e_valid_q, e_valid_d;
    logic            e_legal_q, e_legal_d;
    alu_op_t         e_op_q,    e_op_d;
    logic [XLEN-1:0] e_a_q,     e_a_d;
    logic [XLEN-1:0] e_b_q,     e_b_d;
    logic [AW-1:0]   e_rd_q,    e_rd_d;

    logic            wb_valid_q, wb_valid_d;
    logic [AW-1:0]   wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0] wb_data_q,  wb_data_d;
    logic            illegal_q,  illegal_d;
    logic [31:0]     retired_count_q, retired_count_d;

    logic            accept;
    logic            fwd_ok;
    logic            retire;
    logic            rf_we;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign instr_ready = !hold;
    assign accept      = instr_valid && !hold;

    // E may forward only when it will actually write a real register.
    assign fwd_ok = e_valid_q && e_legal_q && (e_rd_q != '0);
    assign retire = e_valid_q && e_legal_q && !hold;
    assign rf_we  = retire && (e_rd_q != '0);

    // Operand read: x0 -> 0, then forward from E, then register file.
    always_comb begin
        rs1_val = rf_q[dec_c.rs1];
        if (dec_c.rs1 == '0) begin
            rs1_val = '0;
        end else if (fwd_ok && (e_rd_q == dec_c.rs1)) begin
            rs1_val = alu_result;
        end

        rs2_val = rf_q[dec_c.rs2];
        if (dec_c.rs2 == '0) begin
            rs2_val = '0;
        end else if (fwd_ok && (e_rd_q == dec_c.rs2)) begin
            rs2_val = alu_result;
        end
    end

    // Next-state for E, WB, register file and retire counter; all frozen under hold.
    always_comb begin
        e_valid_d       = e_valid_q;
        e_legal_d       = e_legal_q;
        e_op_d          = e_op_q;
        e_a_d           = e_a_q;
        e_b_d           = e_b_q;
        e_rd_d          = e_rd_q;
        wb_valid_d      = 1'b0;
        wb_rd_d         = wb_rd_q;
        wb_data_d       = wb_data_q;
        illegal_d       = 1'b0;
        retired_count_d = retired_count_q;
        rf_d            = rf_q;

        if (!hold) begin
            e_valid_d = accept;
            if (accept) begin
                e_legal_d = dec_c.legal;
                e_op_d    = dec_c.op;
                e_a_d     = rs1_val;
                e_b_d     = dec_c.use_imm ? dec_c.imm : rs2_val;
                e_rd_d    = dec_c.rd;
            end

            illegal_d = e_valid_q && !e_legal_q;

            if (rf_we) begin
                wb_valid_d     = 1'b1;
                wb_rd_d        = e_rd_q;
                wb_data_d      = alu_result;
                rf_d[e_rd_q]   = alu_result;
            end

            if (retire) begin
                retired_count_d = retired_count_q + 32'd1;
            end
        end

        rf_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q       <= 1'b0;
            e_legal_q       <= 1'b0;
            e_op_q          <= ALU_ADD;
            e_a_q           <= '0;
            e_b_q           <= '0;
            e_rd_q          <= '0;
            wb_valid_q      <= 1'b0;
            wb_rd_q         <= '0;
            wb_data_q       <= '0;
            illegal_q       <= 1'b0;
            retired_count_q <= '0;
            rf_q            <= '{default: '0};
        end else begin
            e_valid_q       <= e_valid_d;
            e_legal_q       <= e_legal_d;
            e_op_q          <= e_op_d;
            e_a_q           <= e_a_d;
            e_b_q           <= e_b_d;
            e_rd_q          <= e_rd_d;
            wb_valid_q      <= wb_valid_d;
            wb_rd_q         <= wb_rd_d;
            wb_data_q       <= wb_data_d;
            illegal_q       <= illegal_d;
            retired_count_q <= retired_count_d;
            rf_q            <= rf_d;
        end
    end

    assign alu_a         = e_a_q;
    assign alu_b         = e_b_q;
    assign alu_op        = e_op_q;
    assign wb_valid      = wb_valid_q;
    assign wb_rd         = wb_rd_q;
    assign wb_data       = wb_data_q;
    assign illegal       = illegal_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU in the loop.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] instr = 32'h0;
    logic        hold = 1'b0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [31:0] retired_count;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_issue_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .hold          (hold),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .alu_result    (alu_result),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .illegal       (illegal),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    // Stand-in for picorv32_alu.
    always_comb begin
        case (alu_op)
            4'h0:    alu_result = alu_a + alu_b;
            4'h1:    alu_result = alu_a - alu_b;
            4'h2:    alu_result = alu_a & alu_b;
            4'h3:    alu_result = alu_a | alu_b;
            4'h4:    alu_result = alu_a ^ alu_b;
            default: alu_result = 32'h0;
        endcase
    end

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [4:0] rd, input logic [31:0] data);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
        chk({tag, ".wb_rd"},    32'(wb_rd),    32'(rd));
        chk({tag, ".wb_data"},  wb_data,       data);
    endtask

    // Drive inputs at the falling edge, pass one rising edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic h);
        instr_valid = v;
        instr       = ins;
        hold        = h;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst.alu_a",    alu_a, 32'h0);
        chk("rst.alu_b",    alu_b, 32'h0);
        chk("rst.alu_op",   32'(alu_op), 32'h0);
        chk("rst.wb_valid", 32'(wb_valid), 32'h0);
        chk("rst.illegal",  32'(illegal), 32'h0);
        chk("rst.count",    retired_count, 32'h0);
        chk("rst.ready",    32'(instr_ready), 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic immediates
        cyc(1'b1, enc_i(3'b000, 5'd1, 5'd0, 12'd5), 1'b0);
        chk("imm1.alu_a",  alu_a, 32'h0);
        chk("imm1.alu_b",  alu_b, 32'h5);
        chk("imm1.alu_op", 32'(alu_op), 32'h0);
        chk("imm1.no_wb",  32'(wb_valid), 32'h0);
        cyc(1'b1, enc_i(3'b000, 5'd2, 5'd0, 12'hFFD), 1'b0);
        chk_wb("imm1", 5'd1, 32'h5);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("imm2", 5'd2, 32'hFFFF_FFFD);
        chk("imm.count", retired_count, 32'd2);

        // Back-to-back dependency
        cyc(1'b1, enc_i(3'b000, 5'd1, 5'd0, 12'd7), 1'b0);
        chk("dep.idle_wb", 32'(wb_valid), 32'h0);
        cyc(1'b1, enc_r(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd1), 1'b0);
        chk("dep.alu_a",  alu_a, 32'd7);
        chk("dep.alu_b",  alu_b, 32'd7);
        chk("dep.alu_op", 32'(alu_op), 32'h1);
        chk_wb("dep.x1", 5'd1, 32'd7);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("dep.x3", 5'd3, 32'h0);

        // Hold with a pending dependency
        cyc(1'b1, enc_i(3'b000, 5'd1, 5'd0, 12'h0F0), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, enc_i(3'b100, 5'd4, 5'd1, 12'h0FF), 1'b1);
            chk("hold.wb_valid", 32'(wb_valid), 32'h0);
            chk("hold.ready",    32'(instr_ready), 32'h0);
            chk("hold.alu_b",    alu_b, 32'h0F0);
        end
        cyc(1'b1, enc_i(3'b100, 5'd4, 5'd1, 12'h0FF), 1'b0);
        chk_wb("hold.x1", 5'd1, 32'h0F0);
        chk("hold.alu_a",  alu_a, 32'h0F0);
        chk("hold.alu_b2", alu_b, 32'h0FF);
        chk("hold.alu_op", 32'(alu_op), 32'h4);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("hold.x4", 5'd4, 32'h00F);
        chk("hold.count", retired_count, 32'd6);

        // Illegal encodings
        cyc(1'b1, 32'h0000_0000, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("ill0.illegal", 32'(illegal), 32'h1);
        chk("ill0.no_wb",   32'(wb_valid), 32'h0);
        chk("ill0.count",   retired_count, 32'd6);
        cyc(1'b1, enc_r(7'b0000001, 3'b000, 5'd5, 5'd1, 5'd1), 1'b0);
        chk("ill.pulse_end", 32'(illegal), 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("ill1.illegal", 32'(illegal), 32'h1);
        chk("ill1.count",   retired_count, 32'd6);

        // Writes to x0 retire but never write back
        cyc(1'b1, enc_i(3'b000, 5'd0, 5'd0, 12'd1), 1'b0);
        cyc(1'b1, enc_r(7'b0000000, 3'b000, 5'd7, 5'd0, 5'd1), 1'b0);
        chk("x0.no_wb",  32'(wb_valid), 32'h0);
        chk("x0.alu_a",  alu_a, 32'h0);
        chk("x0.alu_b",  alu_b, 32'h0F0);
        chk("x0.count",  retired_count, 32'd7);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("x0.x7", 5'd7, 32'h0F0);
        chk("x0.count2", retired_count, 32'd8);

        // Logic ops, mixed forwarding and register-file reads
        cyc(1'b1, enc_r(7'b0000000, 3'b111, 5'd9,  5'd1, 5'd2), 1'b0);
        cyc(1'b1, enc_r(7'b0000000, 3'b110, 5'd10, 5'd1, 5'd2), 1'b0);
        chk_wb("and", 5'd9, 32'h0000_00F0);
        cyc(1'b1, enc_r(7'b0000000, 3'b100, 5'd11, 5'd9, 5'd10), 1'b0);
        chk_wb("or", 5'd10, 32'hFFFF_FFFD);
        chk("xor.alu_a", alu_a, 32'h0000_00F0);
        chk("xor.alu_b", alu_b, 32'hFFFF_FFFD);
        cyc(1'b1, enc_i(3'b111, 5'd12, 5'd2, 12'hFF0), 1'b0);
        chk_wb("xor", 5'd11, 32'hFFFF_FF0D);
        chk("andi.alu_b", alu_b, 32'hFFFF_FFF0);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("andi", 5'd12, 32'hFFFF_FFF0);
        chk("logic.count", retired_count, 32'd12);

        // Asynchronous reset with E valid
        cyc(1'b1, enc_i(3'b000, 5'd6, 5'd0, 12'd9), 1'b0);
        instr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.alu_a",    alu_a, 32'h0);
        chk("arst.alu_b",    alu_b, 32'h0);
        chk("arst.wb_valid", 32'(wb_valid), 32'h0);
        chk("arst.count",    retired_count, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, enc_r(7'b0000000, 3'b000, 5'd5, 5'd1, 5'd6), 1'b0);
        chk("arst.no_wb", 32'(wb_valid), 32'h0);
        chk("arst.x1",    alu_a, 32'h0);
        chk("arst.x6",    alu_b, 32'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("arst.x5", 5'd5, 32'h0);
        chk("arst.count2", retired_count, 32'd1);

        // Counter wrap
        force dut.retired_count_d = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.retired_count_d;
        chk("wrap.preset", retired_count, 32'hFFFF_FFFF);
        cyc(1'b1, enc_r(7'b0000000, 3'b000, 5'd13, 5'd0, 5'd0), 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        chk_wb("wrap", 5'd13, 32'h0);
        chk("wrap.count", retired_count, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue/writeback stage that sits directly upstream of `picorv32_alu` and consumes its result. It decodes RV32I register–register and register–immediate ALU instructions (ADD/SUB/AND/OR/XOR and the immediate forms) and reads operands from a local 32×32 register file. It drives `a`/`b`/`alu_op` into the combinational ALU, captures `result`, and writes it back, with forwarding so back-to-back dependent instructions issue without stalls.

## Interface
Parameters:
- `XLEN`, 32, datapath width. Only 32 is supported.
- `NREGS`, 32, register count. x0 is hardwired to zero.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  upstream instruction is valid.
- `instr_ready`  out  1  stage accepts an instruction; equals `!hold`.
- `instr`  in  32  RV32I instruction word.
- `hold`  in  1  freezes the whole stage.
- `alu_a`  out  32  ALU operand a, driven from the E register.
- `alu_b`  out  32  ALU operand b (rs2 value or sign-extended immediate).
- `alu_op`  out  4  ALU opcode.
- `alu_result`  in  32  combinational ALU result.
- `wb_valid`  out  1  registered writeback pulse; set only for legal instructions with rd≠0.
- `wb_rd`  out  5  writeback register index.
- `wb_data`  out  32  writeback value.
- `illegal`  out  1  registered one-cycle pulse for an unsupported instruction.
- `retired_count`  out  32  count of legal instructions retired; wraps.

## Operation
- **Decode, opcode 0110011 (R-type):**
  - funct3=000: funct7=0000000 → ADD; funct7=0100000 → SUB.
  - funct3=111, 110, 100 with funct7=0 → AND, OR, XOR.
- **Decode, opcode 0010011 (I-type):**
  - funct3=000, 111, 110, 100 → ADDI, ANDI, ORI, XORI.
  - b = sign-extended instr[31:20].
- Any other encoding is illegal.
- **alu_op codes:** ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100.
- **Handshake:** accept = `instr_valid && instr_ready`. On accept, the decoded op, operands, rd and legal flag load into the E register and `e_valid` is set. Without an accept, `e_valid` clears (unless `hold`).
- **Operand read:** rsN==0 reads 0. If E is valid and legal, with rd≠0 and rd==rsN, the operand is forwarded from `alu_result`. Otherwise it comes from the register file.
- **Writeback:** in a cycle where E is valid and `!hold`:
  - Legal with rd≠0: regfile[rd] ← `alu_result`; `wb_valid`, `wb_rd`, `wb_data` are registered.
  - Legal with rd=0: no write and no `wb_valid`, but `retired_count` still increments.
  - Illegal: no write and no `wb_valid`; `illegal` pulses.
- **Hold:** E register, WB registers, regfile and counter are frozen. `wb_valid` and `illegal` stay at 0 while held; they are re-evaluated when hold releases. `alu_*` outputs hold their values.
- **retired_count:** +1 per legal instruction leaving E. Wraps 0xFFFFFFFF→0.

## Timing
- **Reset values:** all outputs 0, except `instr_ready`, which follows `!hold`. E register, WB registers and x1–x31 clear to 0.
- **Pipeline:** instruction accepted at edge N → `alu_*` valid in cycle N..N+1 → regfile written and `wb_*` / `illegal` asserted after edge N+1. Latency to `wb_valid` is 2 edges.
- **Throughput:** 1 instruction/cycle with no dependency stalls, via forwarding from E.
- **Same-cycle read/write:** when a D read and an E write target the same register, the forwarded value wins.
- **Reset mid-stream:** the in-flight instruction is dropped and no writeback occurs.

## Structure
- **Package `alu_pkg`:**
  - `alu_op_t` enum (ADD, SUB, AND, OR, XOR, INVALID=4'hF).
  - Opcode constants OPC_OP=7'b0110011 and OPC_OPIMM=7'b0010011.
  - funct3/funct7 constants.
  - `picorv32_alu` is updated to import `alu_op_t`.
- **Sub-module `alu_decoder`:** combinational; instr → {op, rs1, rs2, rd, imm, use_imm, legal}.
- **In `alu_issue_stage`:** the register file, forwarding, and the E/WB registers stay inline.

## Test plan
- **Basic immediates:** `ADDI x1,x0,5` then `ADDI x2,x0,-3` → wb (1, 0x5), then (2, 0xFFFFFFFD); `retired_count`=2.
- **Back-to-back dependency:** `ADDI x1,x0,7`; `SUB x3,x1,x1` → `alu_a`=`alu_b`=7 via forwarding; wb (3, 0).
- **Hold with dependency:** `ADDI x1,x0,0x0F0`; `XORI x4,x1,0x0FF` with `hold` high 3 cycles between them → no `wb_valid` while held; then wb (4, 0x00F).
- **Illegal and x0:** instr 0x0000_0000 → `illegal` pulse, no `wb_valid`, count unchanged. `ADDI x0,x0,1` → no `wb_valid`; x0 still reads 0; count +1.
- **Async reset mid-stream:** `rst` asserted between clock edges with E valid → outputs 0 immediately; x1 reads 0 afterwards; no wb from the dropped instruction.
- **Counter wrap:** force `retired_count`=0xFFFFFFFF, retire one ADD → count 0.
